// File: rtl/ram_xfer_sched.sv
// ram_xfer_sched: SRAM copy/fill engine that borrows the card SRAM only
// inside the PHI1 window (S = 1..3) and hands it back for all of PHI0.
// Optional fill mode is built when XFER_FILL_EN is defined; otherwise every
// transfer is a copy and the Mode/FillVal inputs are ignored.
// A disturbed access (S off its 1-2-3 sequence) drops its strobes on that
// edge and is retried from the start of the following PHI1 window.
module ram_xfer_sched (
  input  logic        c7m_i,
  input  logic        res_i,
  input  logic [2:0]  s_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        mode_i,
  input  logic [23:0] src_i,
  input  logic [23:0] dst_i,
  input  logic [15:0] len_i,
  input  logic [7:0]  fill_val_i,
  input  logic [7:0]  md_i,
  output logic [23:0] ma_o,
  output logic [7:0]  md_o,
  output logic        n_mcs_o,
  output logic        n_mwe_o,
  output logic        own_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        aborted_o,
  output logic [15:0] remaining_o
);

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 16;
  localparam int unsigned SW = 3;

  localparam logic [SW-1:0] S_OPEN = SW'(1);
  localparam logic [SW-1:0] S_MID  = SW'(2);
  localparam logic [SW-1:0] S_LAST = SW'(3);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ACC  = 3'd1,
    WR_ACC  = 3'd2,
    WAITWIN = 3'd3,
    FINISH  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          ph_q, ph_d;             // 0: expect S==2 next, 1: expect S==3
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [DW-1:0] data_q, data_d;
  logic          have_q, have_d;         // copy byte read, write still owed
  logic          abort_pend_q, abort_pend_d;
  logic          own_q, own_d;
  logic [AW-1:0] ma_q, ma_d;
  logic [DW-1:0] mdo_q, mdo_d;
  logic          ncs_q, ncs_d;
  logic          nwe_q, nwe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic [LW-1:0] rem_q, rem_d;

  logic          accept;
  logic          fill_mode;
  logic [DW-1:0] wdata;

  assign accept = (state_q == IDLE) && start_i && !abort_i;

`ifdef XFER_FILL_EN
  logic          mode_q;
  logic [DW-1:0] fill_q;

  // Fill configuration captured alongside the other transfer parameters
  always_ff @(posedge c7m_i) begin
    if (res_i) begin
      mode_q <= 1'b0;
      fill_q <= '0;
    end else if (accept) begin
      mode_q <= mode_i;
      fill_q <= fill_val_i;
    end
  end

  assign fill_mode = mode_q;
  assign wdata     = mode_q ? fill_q : data_q;
`else
  logic unused_fill;
  assign unused_fill = ^{mode_i, fill_val_i};
  assign fill_mode   = 1'b0;
  assign wdata       = data_q;
`endif

  // State and registered-output update
  always_ff @(posedge c7m_i) begin
    if (res_i) begin
      state_q      <= IDLE;
      ph_q         <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      data_q       <= '0;
      have_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      own_q        <= 1'b0;
      ma_q         <= '0;
      mdo_q        <= '0;
      ncs_q        <= 1'b1;
      nwe_q        <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      rem_q        <= '0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      data_q       <= data_d;
      have_q       <= have_d;
      abort_pend_q <= abort_pend_d;
      own_q        <= own_d;
      ma_q         <= ma_d;
      mdo_q        <= mdo_d;
      ncs_q        <= ncs_d;
      nwe_q        <= nwe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      rem_q        <= rem_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    src_d        = src_q;
    dst_d        = dst_q;
    data_d       = data_q;
    have_d       = have_q;
    abort_pend_d = abort_pend_q;
    own_d        = own_q;
    ma_d         = ma_q;
    mdo_d        = mdo_q;
    ncs_d        = ncs_q;
    nwe_d        = nwe_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    rem_d        = rem_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          src_d        = src_i;
          dst_d        = dst_i;
          rem_d        = len_i;
          busy_d       = 1'b1;
          aborted_d    = 1'b0;
          have_d       = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = (len_i == '0) ? FINISH : WAITWIN;
        end
      end

      WAITWIN: begin
        if (abort_i || abort_pend_q) begin
          aborted_d = 1'b1;
          state_d   = FINISH;
        end else if (s_i == S_OPEN) begin
          own_d = 1'b1;
          ncs_d = 1'b0;
          nwe_d = 1'b1;
          ph_d  = 1'b0;
          if (!fill_mode && !have_q) begin
            ma_d    = src_q;
            state_d = RD_ACC;
          end else begin
            ma_d    = dst_q;
            mdo_d   = wdata;
            state_d = WR_ACC;
          end
        end
      end

      RD_ACC, WR_ACC: begin
        if (abort_i) abort_pend_d = 1'b1;
        if (!ph_q && (s_i == S_MID)) begin
          ph_d = 1'b1;
          if (state_q == RD_ACC) data_d = md_i;
          else                   nwe_d  = 1'b0;
        end else if (ph_q && (s_i == S_LAST)) begin
          own_d = 1'b0;
          ncs_d = 1'b1;
          nwe_d = 1'b1;
          if (state_q == RD_ACC) begin
            src_d  = src_q + AW'(1);
            have_d = 1'b1;
          end else begin
            dst_d  = dst_q + AW'(1);
            rem_d  = rem_q - LW'(1);
            have_d = 1'b0;
          end
          if (abort_pend_q || abort_i) begin
            aborted_d = 1'b1;
            state_d   = FINISH;
          end else if ((state_q == WR_ACC) && (rem_q == LW'(1))) begin
            state_d = FINISH;
          end else begin
            state_d = WAITWIN;
          end
        end else begin
          // Bus phase slipped: release the SRAM now and retry next window
          own_d   = 1'b0;
          ncs_d   = 1'b1;
          nwe_d   = 1'b1;
          state_d = WAITWIN;
        end
      end

      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign ma_o        = ma_q;
  assign md_o        = mdo_q;
  assign n_mcs_o     = ncs_q;
  assign n_mwe_o     = nwe_q;
  assign own_o       = own_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign remaining_o = rem_q;

endmodule

// File: tb/tb_ram_xfer_sched.sv
// Bench for ram_xfer_sched: drives a free-running 1..7 bus phase, models the
// SRAM read data, and scores every committed write against an expected queue.
module tb_ram_xfer_sched;

  logic        c7m_i;
  logic        res_i;
  logic [2:0]  s_i;
  logic        start_i;
  logic        abort_i;
  logic        mode_i;
  logic [23:0] src_i;
  logic [23:0] dst_i;
  logic [15:0] len_i;
  logic [7:0]  fill_val_i;
  logic [7:0]  md_i;
  logic [23:0] ma_o;
  logic [7:0]  md_o;
  logic        n_mcs_o;
  logic        n_mwe_o;
  logic        own_o;
  logic        busy_o;
  logic        done_o;
  logic        aborted_o;
  logic [15:0] remaining_o;

  ram_xfer_sched dut (
    .c7m_i(c7m_i), .res_i(res_i), .s_i(s_i), .start_i(start_i),
    .abort_i(abort_i), .mode_i(mode_i), .src_i(src_i), .dst_i(dst_i),
    .len_i(len_i), .fill_val_i(fill_val_i), .md_i(md_i), .ma_o(ma_o),
    .md_o(md_o), .n_mcs_o(n_mcs_o), .n_mwe_o(n_mwe_o), .own_o(own_o),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
    .remaining_o(remaining_o)
  );

  typedef struct {
    logic [23:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  mem [logic [23:0]];

  int n_tests, n_fail;
  int cyc, start_cyc, done_cyc, done_cnt;
  int commits, we_pulses, ncs_low_cnt, own_rise;
  logic own_prev, glitch_arm, glitch_pend;

  initial c7m_i = 1'b0;
  always #5 c7m_i = ~c7m_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic commit();
    wr_t e;
    commits++;
    if (exp_q.size() == 0) begin
      chk("unexpected_write", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("wr_addr", ma_o, e.a);
      chk("wr_data", md_o, e.d);
    end
  endtask

  // One clock: observe the edge just past, then present the next bus phase
  task automatic step();
    logic [2:0] nxt;
    @(negedge c7m_i);
    cyc++;
    if (glitch_pend) begin
      chk("resync_nwe", n_mwe_o, 32'd1);
      chk("resync_own", own_o, 32'd0);
      chk("resync_ncs", n_mcs_o, 32'd1);
      glitch_pend = 1'b0;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!n_mcs_o) ncs_low_cnt++;
    if (own_o && !own_prev) own_rise++;
    own_prev = own_o;
    nxt = (s_i == 3'd0 || s_i == 3'd7) ? 3'd1 : 3'(s_i + 3'd1);
    if (glitch_arm && !n_mwe_o) begin
      nxt         = 3'd1;
      glitch_arm  = 1'b0;
      glitch_pend = 1'b1;
    end
    s_i = nxt;
    if (!n_mwe_o) begin
      we_pulses++;
      if (s_i == 3'd3) commit();
    end
    chk("we_without_cs", (!n_mwe_o && n_mcs_o), 32'd0);
    if (s_i == 3'd0 || s_i >= 3'd4) begin
      chk("phi0_own", own_o, 32'd0);
      chk("phi0_ncs", n_mcs_o, 32'd1);
    end
    md_i = mem.exists(ma_o) ? mem[ma_o] : 8'h00;
  endtask

  task automatic start_xfer(input logic [23:0] src, input logic [23:0] dst,
                            input logic [15:0] len, input logic mode, input logic [7:0] fv);
    src_i = src; dst_i = dst; len_i = len; mode_i = mode; fill_val_i = fv;
    start_i = 1'b1;
    start_cyc = cyc;
    step();
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_own"},  own_o, 32'd0);
    chk({tag, "_ncs"},  n_mcs_o, 32'd1);
    chk({tag, "_nwe"},  n_mwe_o, 32'd1);
    chk({tag, "_ma"},   ma_o, 32'd0);
    chk({tag, "_md"},   md_o, 32'd0);
    chk({tag, "_busy"}, busy_o, 32'd0);
    chk({tag, "_done"}, done_o, 32'd0);
    chk({tag, "_abrt"}, aborted_o, 32'd0);
    chk({tag, "_rem"},  remaining_o, 32'd0);
  endtask

  initial begin
    int d0, c0, p0, r0, n;
    n_tests = 0; n_fail = 0; cyc = 0; done_cnt = 0; done_cyc = 0; start_cyc = 0;
    commits = 0; we_pulses = 0; ncs_low_cnt = 0; own_rise = 0;
    own_prev = 1'b0; glitch_arm = 1'b0; glitch_pend = 1'b0;
    res_i = 1'b1; s_i = 3'd0; start_i = 1'b0; abort_i = 1'b0; mode_i = 1'b0;
    src_i = '0; dst_i = '0; len_i = '0; fill_val_i = '0; md_i = '0;
    mem[24'h000100] = 8'hAA; mem[24'h000101] = 8'h55; mem[24'h000102] = 8'h01;
    for (int i = 0; i < 5; i++) mem[24'h000300 + 24'(i)] = 8'(8'h11 * (i + 1));
    mem[24'h000400] = 8'h9A; mem[24'h000401] = 8'hBC;
    mem[24'h000500] = 8'h7E;
    mem[24'h000200] = 8'h42;

    // Reset state
    repeat (3) step();
    check_reset_vals("reset");
    res_i = 1'b0;
    repeat (2) step();

    // Three-byte copy
    exp_q.push_back('{24'h080000, 8'hAA});
    exp_q.push_back('{24'h080001, 8'h55});
    exp_q.push_back('{24'h080002, 8'h01});
    d0 = done_cnt; c0 = commits; r0 = own_rise;
    start_xfer(24'h000100, 24'h080000, 16'd3, 1'b0, 8'h00);
    chk("copy_busy", busy_o, 32'd1);
    chk("copy_rem_load", remaining_o, 32'd3);
    run_until_done(200);
    repeat (10) step();
    chk("copy_done_cnt", done_cnt - d0, 32'd1);
    chk("copy_writes", commits - c0, 32'd3);
    chk("copy_windows", own_rise - r0, 32'd6);
    chk("copy_rem", remaining_o, 32'd0);
    chk("copy_busy_end", busy_o, 32'd0);
    chk("copy_abrt", aborted_o, 32'd0);
    chk("copy_sb_left", exp_q.size(), 32'd0);

    // Abort during the read of byte 2 of a five-byte copy
    exp_q.push_back('{24'h0A0000, 8'h11});
    d0 = done_cnt;
    start_xfer(24'h000300, 24'h0A0000, 16'd5, 1'b0, 8'h00);
    n = 0;
    while (!(own_o && ma_o == 24'h000301) && n < 100) begin
      step();
      n++;
    end
    chk("abort_reach_rd2", (own_o && ma_o == 24'h000301), 32'd1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    run_until_done(100);
    repeat (20) step();
    chk("abort_done_cnt", done_cnt - d0, 32'd1);
    chk("abort_flag", aborted_o, 32'd1);
    chk("abort_rem", remaining_o, 32'd4);
    chk("abort_busy", busy_o, 32'd0);
    chk("abort_sb_left", exp_q.size(), 32'd0);

    // Zero-length transfer; also clears Aborted
    d0 = done_cnt; p0 = ncs_low_cnt;
    start_xfer(24'h000100, 24'h0E0000, 16'd0, 1'b0, 8'h00);
    chk("len0_abrt_clr", aborted_o, 32'd0);
    run_until_done(10);
    chk("len0_done_lat", done_cyc - start_cyc, 32'd2);
    step();
    chk("len0_done_cnt", done_cnt - d0, 32'd1);
    chk("len0_no_cs", ncs_low_cnt - p0, 32'd0);
    chk("len0_busy", busy_o, 32'd0);

    // Bus phase resyncs to 1 in the middle of the first write
    exp_q.push_back('{24'h0B0000, 8'h9A});
    exp_q.push_back('{24'h0B0001, 8'hBC});
    c0 = commits; p0 = we_pulses;
    glitch_arm = 1'b1;
    start_xfer(24'h000400, 24'h0B0000, 16'd2, 1'b0, 8'h00);
    run_until_done(200);
    chk("resync_fired", glitch_arm, 32'd0);
    chk("resync_writes", commits - c0, 32'd2);
    chk("resync_pulses", we_pulses - p0, 32'd3);
    chk("resync_rem", remaining_o, 32'd0);
    chk("resync_sb_left", exp_q.size(), 32'd0);

    // Start pulses while busy are ignored
    exp_q.push_back('{24'h0C0000, 8'h7E});
    d0 = done_cnt;
    start_xfer(24'h000500, 24'h0C0000, 16'd1, 1'b0, 8'h00);
    repeat (3) step();
    start_xfer(24'h000100, 24'h0D0000, 16'd0, 1'b0, 8'h00);
    run_until_done(100);
    repeat (20) step();
    chk("busy_start_done", done_cnt - d0, 32'd1);
    chk("busy_start_sb", exp_q.size(), 32'd0);

    // Start with Abort in IDLE is ignored
    d0 = done_cnt;
    abort_i = 1'b1;
    start_xfer(24'h000100, 24'h0D0000, 16'd2, 1'b0, 8'h00);
    abort_i = 1'b0;
    chk("start_abort_busy", busy_o, 32'd0);
    repeat (10) step();
    chk("start_abort_done", done_cnt - d0, 32'd0);

`ifdef XFER_FILL_EN
    // Fill across the 24-bit wrap
    exp_q.push_back('{24'hFFFFFE, 8'hE5});
    exp_q.push_back('{24'hFFFFFF, 8'hE5});
    exp_q.push_back('{24'h000000, 8'hE5});
    exp_q.push_back('{24'h000001, 8'hE5});
    c0 = commits; r0 = own_rise;
    start_xfer(24'h000100, 24'hFFFFFE, 16'd4, 1'b1, 8'hE5);
    run_until_done(200);
    chk("fill_writes", commits - c0, 32'd4);
    chk("fill_windows", own_rise - r0, 32'd4);
    chk("fill_sb_left", exp_q.size(), 32'd0);
`endif

    // Reset in the middle of a read access
    start_xfer(24'h000200, 24'h090000, 16'd3, 1'b0, 8'h00);
    n = 0;
    while (!own_o && n < 100) begin
      step();
      n++;
    end
    chk("rstmid_reach", own_o, 32'd1);
    res_i = 1'b1;
    step();
    check_reset_vals("rstmid");
    res_i = 1'b0;
    p0 = we_pulses;
    repeat (30) step();
    chk("rstmid_no_write", we_pulses - p0, 32'd0);
    chk("rstmid_busy", busy_o, 32'd0);
    chk("rstmid_sb_left", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_xfer_sched.md
RAM_XFER_SCHED -- requirements
Module: ram_xfer_sched

Interface
REQ-001 C7M  in  1  sole clock, 7.16 MHz; all state updates on rising edge.
REQ-002 RES  in  1  reset, synchronous, active-high.
REQ-003 S  in  3  bus phase from card timing block; 0 = unsynced, 1-3 = PHI1 window, 4-7 = PHI0.
REQ-004 Start  in  1  one-cycle pulse launching a transfer; ignored while Busy.
REQ-005 Abort  in  1  level; requests early termination.
REQ-006 Mode  in  1  0 = copy Src->Dst, 1 = fill Dst with FillVal.
REQ-007 Src, Dst  in  24 each  start addresses, sampled on accepted Start.
REQ-008 Len  in  16  byte count, sampled on accepted Start.
REQ-009 FillVal  in  8  fill byte, sampled on accepted Start.
REQ-010 MDin  in  8  SRAM read data.
REQ-011 MA  out  24  engine SRAM address; MDout  out  8  engine write data.
REQ-012 nMCS, nMWE  out  1 each  engine SRAM chip select / write strobe, active-low.
REQ-013 Own  out  1  engine drives SRAM pins this cycle; card mux selects MA/MDout/nMCS/nMWE only when Own=1.
REQ-014 Busy  out  1; Done  out  1 (one-cycle pulse); Aborted  out  1; Remaining  out  16.

Function
REQ-015 States: IDLE, RD_ACC, WR_ACC, WAITWIN, FINISH.
REQ-016 Accepted Start in IDLE latches Src/Dst/Len/FillVal/Mode into working registers, Remaining<=Len, Busy<=1, next WAITWIN.
REQ-017 Len=0: next state FINISH directly; no SRAM access; Done pulses 2 cycles after Start.
REQ-018 Access begins only on an edge where S==1; never when S is 0 or 4-7, so the 6502 owns SRAM during all of PHI0.
REQ-019 Read access (copy): S==1 edge -> Own=1, MA=SrcPtr, nMCS=0, nMWE=1; S==2 edge -> latch MDin to data register; S==3 edge -> nMCS=1, Own=0, SrcPtr+1.
REQ-020 Write access: S==1 edge -> Own=1, MA=DstPtr, MDout=data (fill: FillVal), nMCS=0; S==2 edge -> nMWE=0; S==3 edge -> nMWE=1, nMCS=1, Own=0, DstPtr+1, Remaining-1.
REQ-021 Copy byte = read in one PHI1 window, write in the next; fill byte = one write per window.
REQ-022 Pointers are 24-bit and wrap FFFFFF->000000 silently.
REQ-023 After a write with Remaining reaching 0: FINISH; FINISH emits Done=1 one cycle, Busy<=0, back to IDLE.
REQ-024 If S deviates from the expected next value mid-access (resync to 1, or 0, or >=4), strobes deassert and Own=0 on that edge; the same access retries at the next S==1; pointers and Remaining unchanged.
REQ-025 Abort seen in WAITWIN: FINISH next cycle with Aborted=1. Abort mid-access: current access completes through S==3, then FINISH with Aborted=1; a copy aborted between read and write does not write.
REQ-026 Aborted stays set until next accepted Start; Remaining retains unwritten count.
REQ-027 Start and Abort in same cycle while IDLE: Start ignored.
REQ-028 nMWE never low while nMCS high; nMWE low exactly one cycle per write.

Reset
REQ-029 RES=1 at a clock edge: state IDLE, Busy=0, Done=0, Aborted=0, Own=0, nMCS=1, nMWE=1, MA=0, MDout=0, Remaining=0, pointers 0.
REQ-030 RES mid-access deasserts strobes at that edge; no partial write completes afterward.

Configuration
REQ-031 Macro XFER_FILL_EN: defined -> Mode and FillVal honoured per REQ-020/021; undefined -> Mode and FillVal ignored, every transfer is copy, fill logic absent.

Verification
REQ-032 Copy Src=000100, Dst=080000, Len=3, bytes AA,55,01 -> writes 080000..080002 = AA,55,01 over 6 PHI1 windows, Done once, Remaining=0.
REQ-033 Fill (XFER_FILL_EN) Dst=FFFFFE, Len=4, FillVal=E5 -> writes FFFFFE, FFFFFF, 000000, 000001 = E5 in 4 windows.
REQ-034 Len=0 Start -> no nMCS low, Done 2 cycles after Start, Busy low again.
REQ-035 S forced 1,2,1 mid-write -> nMWE returns high at resync edge, write retried at same address next window, total writes = Len.
REQ-036 Abort asserted during read of byte 2 of Len=5 copy -> byte 2 not written, Aborted=1, Remaining=4, Done pulses.
REQ-037 Throughout all runs -> Own=0, nMCS=1 whenever S is 0 or 4-7; RES mid-transfer -> all outputs at REQ-029 values next cycle.
